// File: rtl/uart_pkg.sv
// Shared UART package: arbiter state encoding and the default frame width.
package uart_pkg;

    localparam int DEFAULT_DATA_SIZE = 7;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        ISSUE     = 2'b01,
        WAIT_BUSY = 2'b10,
        WAIT_DONE = 2'b11
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first valid index after `last`, wrapping.
module rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   last,
    output logic               any,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W-1:0] cand;

    // Walk the offsets from farthest to nearest so the nearest valid one wins.
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(last) + k) % NUM_REQ);
            if (valid[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ producers.
// Optional start-acknowledge timeout enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int NUM_REQ        = 4,
    parameter  int DATA_SIZE      = DEFAULT_DATA_SIZE,
    parameter  int TIMEOUT_CYCLES = 64,
    localparam int IDX_W          = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_SIZE-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [DATA_SIZE-1:0]         tx_data,
    output logic                         tx_start,
    input  logic                         tx_busy,
    output logic [IDX_W-1:0]             grant_id,
    output logic                         arb_busy,
    output logic                         timeout_err
);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("uart_tx_arbiter: unsupported parameter value");
    end

    arb_state_t           state, state_nx;
    logic [IDX_W-1:0]     last, last_nx;
    logic [IDX_W-1:0]     grant_nx;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_any;
    logic [DATA_SIZE-1:0] tx_data_nx;
    logic [NUM_REQ-1:0]   req_ready_nx;
    logic                 timeout_nx;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt, tmo_cnt_nx;
`endif

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .valid (req_valid),
        .last  (last),
        .any   (pick_any),
        .idx   (pick_idx)
    );

    // Next-state logic; every output is registered from these next values.
    always_comb begin
        state_nx     = state;
        last_nx      = last;
        grant_nx     = grant_id;
        tx_data_nx   = tx_data;
        req_ready_nx = '0;
        timeout_nx   = 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
        tmo_cnt_nx   = tmo_cnt;
`endif
        unique case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nx = ISSUE;
                    grant_nx = pick_idx;
                    last_nx  = pick_idx;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (pick_idx == IDX_W'(i)) begin
                            tx_data_nx      = req_data[i*DATA_SIZE +: DATA_SIZE];
                            req_ready_nx[i] = 1'b1;
                        end
                    end
                end
            end
            ISSUE: begin
                state_nx = WAIT_BUSY;
`ifdef UART_TX_ARB_TIMEOUT_EN
                tmo_cnt_nx = '0;
`endif
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_nx = WAIT_DONE;
                end
`ifdef UART_TX_ARB_TIMEOUT_EN
                // The word is abandoned; `last` stays advanced past it.
                else if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_nx   = IDLE;
                    timeout_nx = 1'b1;
                end else begin
                    tmo_cnt_nx = tmo_cnt + 1'b1;
                end
`endif
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            last        <= IDX_W'(NUM_REQ - 1);
            grant_id    <= '0;
            tx_data     <= '0;
            tx_start    <= 1'b0;
            req_ready   <= '0;
            arb_busy    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nx;
            last        <= last_nx;
            grant_id    <= grant_nx;
            tx_data     <= tx_data_nx;
            tx_start    <= (state_nx == ISSUE);
            req_ready   <= req_ready_nx;
            arb_busy    <= (state_nx != IDLE);
            timeout_err <= timeout_nx;
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt_nx;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with a simple transmitter model.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DW      = 7;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic [NUM_REQ-1:0]      req_valid = '0;
    logic [NUM_REQ*DW-1:0]   req_data = '0;
    logic [NUM_REQ-1:0]      req_ready;
    logic [DW-1:0]           tx_data;
    logic                    tx_start;
    logic                    tx_busy;
    logic [1:0]              grant_id;
    logic                    arb_busy;
    logic                    timeout_err;

    int checks   = 0;
    int failures = 0;

    // Transmitter model controls
    logic model_en = 1'b1;
    int   busy_len = 20;
    logic pending;
    int   busy_cnt;

    uart_tx_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .DATA_SIZE      (DW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .arb_busy    (arb_busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Transmitter: samples start, busy rises one edge later, stays high busy_len cycles.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pending  <= 1'b0;
            tx_busy  <= 1'b0;
            busy_cnt <= 0;
        end else if (tx_start && model_en) begin
            pending <= 1'b1;
        end else if (pending) begin
            pending  <= 1'b0;
            tx_busy  <= 1'b1;
            busy_cnt <= busy_len;
        end else if (tx_busy) begin
            if (busy_cnt <= 1) tx_busy <= 1'b0;
            else busy_cnt <= busy_cnt - 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic waitStart(input string tag, input int limit);
        logic found;
        found = 1'b0;
        for (int n = 0; n < limit && !found; n++) begin
            @(negedge clk);
            if (tx_start === 1'b1) found = 1'b1;
        end
        checkOutput({tag, "_start_seen"}, 32'(found), 32'd1);
    endtask

    task automatic waitIdle(input string tag, input int limit);
        logic found;
        found = 1'b0;
        for (int n = 0; n < limit && !found; n++) begin
            @(negedge clk);
            if (arb_busy === 1'b0) found = 1'b1;
        end
        checkOutput({tag, "_idle_seen"}, 32'(found), 32'd1);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_tx_data"},   32'(tx_data),     32'h0);
        checkOutput({tag, "_tx_start"},  32'(tx_start),    32'h0);
        checkOutput({tag, "_req_ready"}, 32'(req_ready),   32'h0);
        checkOutput({tag, "_grant_id"},  32'(grant_id),    32'h0);
        checkOutput({tag, "_arb_busy"},  32'(arb_busy),    32'h0);
        checkOutput({tag, "_timeout"},   32'(timeout_err), 32'h0);
    endtask

    initial begin
        int   starts, rises, fall_n, idle_n, s, bad_ready;
        logic data_ok, prev_busy;
        int   g_exp [5];
        int   d_exp [5];
        int   g_got [5];
        int   d_got [5];
        int   r_got [5];
        int   te_n, st_n, st_grant;
        logic arb9, te10, arb30;

        $display("[TB] reset state");
        repeat (3) @(negedge clk);
        checkResetValues("reset");

        // ---- single requester, busy 20 cycles ----
        $display("[TB] single requester");
        reset = 1'b0;
        @(negedge clk);
        req_data[DW-1:0] = 7'h55;
        req_valid = 4'b0001;
        waitStart("single", 5);
        checkOutput("single_ready", 32'(req_ready), 32'h1);
        checkOutput("single_busy",  32'(arb_busy),  32'h1);
        checkOutput("single_data",  32'(tx_data),   32'h55);
        checkOutput("single_grant", 32'(grant_id),  32'h0);
        starts = 0; fall_n = -1; idle_n = -1; data_ok = 1'b1; prev_busy = 1'b0;
        for (int n = 1; n <= 60 && idle_n < 0; n++) begin
            @(negedge clk);
            if (n == 1) req_valid = '0;
            if (tx_start === 1'b1) starts++;
            if (prev_busy && tx_busy === 1'b0 && fall_n < 0) fall_n = n;
            prev_busy = tx_busy;
            if (arb_busy === 1'b0) idle_n = n;
            else if (tx_data !== 7'h55) data_ok = 1'b0;
        end
        checkOutput("single_extra_starts", 32'(starts), 32'd0);
        checkOutput("single_data_held",    32'(data_ok), 32'd1);
        checkOutput("single_busy_fall_n",  32'(fall_n), 32'd22);
        checkOutput("single_idle_n",       32'(idle_n), 32'd23);

        // ---- all four continuously valid ----
        $display("[TB] four requesters");
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        busy_len = 4;
        req_data = {7'h13, 7'h12, 7'h11, 7'h10};
        req_valid = 4'b1111;
        g_exp = '{0, 1, 2, 3, 0};
        d_exp = '{'h10, 'h11, 'h12, 'h13, 'h10};
        s = 0; starts = 0; rises = 0; prev_busy = 1'b0; idle_n = -1;
        for (int n = 0; n < 300 && idle_n < 0; n++) begin
            @(negedge clk);
            if (tx_busy === 1'b1 && !prev_busy) rises++;
            prev_busy = tx_busy;
            if (tx_start === 1'b1) begin
                starts++;
                if (s < 5) begin
                    g_got[s] = int'(grant_id);
                    d_got[s] = int'(tx_data);
                    r_got[s] = int'(req_ready);
                    s++;
                    if (s == 5) req_valid = '0;
                end
            end
            if (s == 5 && arb_busy === 1'b0) idle_n = n;
        end
        checkOutput("rr_frames", 32'(s), 32'd5);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("rr_grant%0d", i), 32'(g_got[i]), 32'(g_exp[i]));
            checkOutput($sformatf("rr_data%0d", i),  32'(d_got[i]), 32'(d_exp[i]));
            checkOutput($sformatf("rr_ready%0d", i), 32'(r_got[i]), 32'(1 << g_exp[i]));
        end
        checkOutput("rr_starts", 32'(starts), 32'd5);
        checkOutput("rr_busy_periods", 32'(rises), 32'd5);

        // ---- grant 3, then 1 and 3 valid ----
        $display("[TB] requesters 1 and 3");
        req_data = {7'h33, 7'h00, 7'h21, 7'h00};
        req_valid = 4'b1000;
        s = 0; bad_ready = 0; idle_n = -1;
        for (int n = 0; n < 300 && idle_n < 0; n++) begin
            @(negedge clk);
            if (req_ready[0] === 1'b1 || req_ready[2] === 1'b1) bad_ready++;
            if (tx_start === 1'b1 && s < 3) begin
                g_got[s] = int'(grant_id);
                d_got[s] = int'(tx_data);
                if (s == 0) begin
                    req_data = {7'h34, 7'h00, 7'h21, 7'h00};
                    req_valid = 4'b1010;
                end else if (s == 1) begin
                    req_valid = 4'b1000;
                end else begin
                    req_valid = 4'b0000;
                end
                s++;
            end
            if (s == 3 && arb_busy === 1'b0) idle_n = n;
        end
        checkOutput("pair_frames", 32'(s), 32'd3);
        checkOutput("pair_grant0", 32'(g_got[0]), 32'd3);
        checkOutput("pair_grant1", 32'(g_got[1]), 32'd1);
        checkOutput("pair_data1",  32'(d_got[1]), 32'h21);
        checkOutput("pair_grant2", 32'(g_got[2]), 32'd3);
        checkOutput("pair_data2",  32'(d_got[2]), 32'h34);
        checkOutput("pair_no_0_2", 32'(bad_ready), 32'd0);

        // ---- reset during WAIT_DONE ----
        $display("[TB] reset mid-frame");
        busy_len = 20;
        req_data = {7'h00, 7'h42, 7'h00, 7'h50};
        req_valid = 4'b0100;
        waitStart("midrst", 5);
        checkOutput("midrst_grant", 32'(grant_id), 32'd2);
        @(negedge clk);
        req_valid = '0;
        repeat (4) @(negedge clk);
        checkOutput("midrst_busy_before", 32'(arb_busy), 32'd1);
        reset = 1'b1;
        #1;
        checkResetValues("midrst");
        @(negedge clk);
        reset = 1'b0;
        req_data = {7'h00, 7'h52, 7'h00, 7'h50};
        req_valid = 4'b0101;
        waitStart("after_rst", 5);
        checkOutput("after_rst_grant", 32'(grant_id), 32'd0);
        checkOutput("after_rst_data",  32'(tx_data),  32'h50);
        @(negedge clk);
        req_valid = '0;
        waitIdle("after_rst", 60);

        // ---- transmitter never acknowledges ----
        $display("[TB] stuck busy");
        @(negedge clk);
        model_en = 1'b0;
        req_data = {7'h00, 7'h62, 7'h61, 7'h00};
        req_valid = 4'b0010;
        waitStart("stuck", 5);
        checkOutput("stuck_grant", 32'(grant_id), 32'd1);
        te_n = -1; st_n = -1; st_grant = -1; arb9 = 1'bx; te10 = 1'bx; arb30 = 1'bx;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (n == 1) req_valid = 4'b0100;
            if (timeout_err === 1'b1 && te_n < 0) te_n = n;
            if (tx_start === 1'b1 && st_n < 0) begin
                st_n = n;
                st_grant = int'(grant_id);
            end
            if (n == 9)  arb9 = arb_busy;
            if (n == 10) te10 = timeout_err;
            if (n == 30) arb30 = arb_busy;
        end
`ifdef UART_TX_ARB_TIMEOUT_EN
        checkOutput("tmo_pulse_n",   32'(te_n),     32'd9);
        checkOutput("tmo_idle",      32'(arb9),     32'd0);
        checkOutput("tmo_one_cycle", 32'(te10),     32'd0);
        checkOutput("tmo_next_n",    32'(st_n),     32'd10);
        checkOutput("tmo_next_grant",32'(st_grant), 32'd2);
`else
        checkOutput("notmo_no_pulse", 32'(te_n),  32'hffffffff);
        checkOutput("notmo_busy9",    32'(arb9),  32'd1);
        checkOutput("notmo_busy30",   32'(arb30), 32'd1);
        checkOutput("notmo_no_grant", 32'(st_n),  32'hffffffff);
        checkOutput("notmo_te10",     32'(te10),  32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one UART transmit shift register between NUM_REQ byte producers. It grants one requester at a time and latches its word. It then sequences the transmitter's start/busy handshake and waits for the frame to finish before granting again. It sits between producer blocks (command echo, status reporter, debug dump) and the transmitter's `d_i`/`tx_start`/`tx_busy` ports.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_SIZE`, 7: data bits per frame; must match the transmitter.
- `TIMEOUT_CYCLES`, 64: maximum wait for `tx_busy` to rise after `tx_start` (only with the timeout feature).
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester word available; held until accepted.
- `req_data`  in  NUM_REQ*DATA_SIZE  requester i word in bits [i*DATA_SIZE +: DATA_SIZE].
- `req_ready`  out  NUM_REQ  one-hot, one-cycle accept pulse.
- `tx_data`  out  DATA_SIZE  word to transmitter `d_i`.
- `tx_start`  out  1  one-cycle start pulse to transmitter.
- `tx_busy`  in  1  transmitter busy.
- `grant_id`  out  $clog2(NUM_REQ)  index of the current or last granted requester.
- `arb_busy`  out  1  high in every state except IDLE.
- `timeout_err`  out  1  one-cycle pulse when a start was not acknowledged.

## Operation
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE, any `req_valid` set:
  - Winner g is the first valid index searching from `last+1` upward, wrapping modulo NUM_REQ.
  - Latch `req_data[g]` into `tx_data`, set `grant_id=g` and `last=g`, go to ISSUE.
- ISSUE, one cycle: `tx_start=1`, `req_ready[g]=1`, then go to WAIT_BUSY.
- WAIT_BUSY: stay until `tx_busy=1`, then go to WAIT_DONE.
- WAIT_DONE: stay until `tx_busy=0`, then go to IDLE.
- `tx_data` holds stable from ISSUE through the end of WAIT_DONE and changes only on a new capture.
- Acceptance rule: a requester's word is accepted when it samples `req_ready[i]&req_valid[i]` at a clock edge. It then drops `req_valid` or presents its next word.
- Requests that arrive in non-IDLE states wait; there is no queueing.
- A `req_valid` deasserted before capture is simply not granted; there is no error.
- All outputs are registered.
- Reset values: state IDLE, `tx_data=0`, `tx_start=0`, `req_ready=0`, `grant_id=0`, `last=NUM_REQ-1` (so requester 0 wins first), `arb_busy=0`, `timeout_err=0`, timeout counter 0.
- Reset asserted mid-frame aborts the sequence immediately. Transmitter recovery is the transmitter's own concern, since it shares `reset`.

## Timing
- Capture edge E0.
- Cycle after E0: `tx_start=1`, `req_ready[g]=1`, `arb_busy=1`.
- Transmitter leaves WAITING at E1; `tx_busy` rises after E2; the arbiter enters WAIT_DONE at E3.
- IDLE is re-entered one edge after `tx_busy` falls. The next capture can occur at that same edge +1, so the inter-frame gap is at most 2 cycles beyond the transmitter's own.
- Fairness: a continuously valid requester is granted within NUM_REQ frames.
- Single requester: back-to-back grants to the same index are allowed.
- Simultaneous `tx_busy` fall and new `req_valid`: the arbiter goes to IDLE first, and the capture happens on the following edge.

## Configuration
- Macro: `UART_TX_ARB_TIMEOUT_EN`.
- Defined:
  - A counter runs in WAIT_BUSY, cleared on entry.
  - If `TIMEOUT_CYCLES` cycles elapse with `tx_busy=0`: pulse `timeout_err` for one cycle and return to IDLE. `last` stays advanced and the word is dropped.
- Undefined: WAIT_BUSY waits indefinitely, there is no counter, and `timeout_err` is tied to 0.

## Structure
- Shared package `uart_pkg` holds:
  - the state encoding constants (IDLE=2'b00, ISSUE=2'b01, WAIT_BUSY=2'b10, WAIT_DONE=2'b11);
  - the default `DATA_SIZE`.
- Sub-module `rr_pick`: combinational round-robin selector with inputs `valid[NUM_REQ]` and `last`, and outputs `any` and `idx`. It is reusable by the receive-side dispatcher.

## Test plan
- Single requester: req 0 valid with 7'h55 and a transmitter model with busy high for 20 cycles. Expect:
  - `tx_start` pulse once and `req_ready[0]` in the same cycle;
  - `tx_data=7'h55` held until busy falls;
  - `arb_busy` low 1 cycle after busy falls.
- All four requesters continuously valid (words 7'h10..7'h13): grant order 0,1,2,3,0; exactly one `tx_start` per busy period.
- Requesters 1 and 3 valid after a grant to 3: next grant is 1, then 3; 0 and 2 are never pulsed.
- Reset asserted during WAIT_DONE:
  - all outputs return to their reset values asynchronously;
  - after release, requester 0 is granted first.
- With `UART_TX_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, `tx_busy` stuck low: `timeout_err` pulses 8 cycles after WAIT_BUSY entry, the arbiter returns to IDLE, and the next requester is served.
- Without the macro, same stimulus: the arbiter stays in WAIT_BUSY, `timeout_err` stays 0, and there are no further grants.
